// File: rtl/store_narrow_buffer_if.sv
// Store-request and memory-drain signal bundle for store_narrow_buffer.
// master = pipeline/memory side, slave = the buffer itself.
interface store_narrow_buffer_if #(
  parameter int CNT_W = 3
);
  logic             st_valid;
  logic             st_ready;
  logic [1:0]       st_size;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic             misalign_err;
  logic             mem_valid;
  logic             mem_ready;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic [CNT_W-1:0] count;

  modport master (
    output st_valid,
    output st_size,
    output st_addr,
    output st_data,
    output mem_ready,
    input  st_ready,
    input  misalign_err,
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    input  count
  );

  modport slave (
    input  st_valid,
    input  st_size,
    input  st_addr,
    input  st_data,
    input  mem_ready,
    output st_ready,
    output misalign_err,
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    output count
  );
endinterface

// File: rtl/store_narrow_buffer.sv
// Narrows SB/SH/SW stores into lane-replicated words with byte enables
// and queues them in a small FIFO that drains to data memory.
module store_narrow_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  store_narrow_buffer_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  ent_t             fifo_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  ent_t ent_d;
  ent_t head;
  logic legal;
  logic is_b, is_h, is_w;
  logic full, empty;
  logic accept, push, pop;

  assign is_b = (bus.st_size == 2'b00);
  assign is_h = (bus.st_size == 2'b01);
  assign is_w = (bus.st_size == 2'b10);

  always_comb begin
    ent_d      = '0;
    legal      = 1'b0;
    ent_d.addr = bus.st_addr[31:2];
    unique case (1'b1)
      is_b: begin
        legal       = 1'b1;
        ent_d.be    = 4'b0001 << bus.st_addr[1:0];
        ent_d.wdata = {4{bus.st_data[7:0]}};
      end
      is_h: begin
        legal       = !bus.st_addr[0];
        ent_d.be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        ent_d.wdata = {2{bus.st_data[15:0]}};
      end
      is_w: begin
        legal       = (bus.st_addr[1:0] == 2'b00);
        ent_d.be    = 4'b1111;
        ent_d.wdata = bus.st_data;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign accept = bus.st_valid && !full;
  assign push   = accept && legal;
  assign pop    = !empty && bus.mem_ready;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    err_d    = accept && !legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= ent_d;
    end
  end

  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (!empty) begin
      bus.mem_addr  = {head.addr, 2'b00};
      bus.mem_wdata = head.wdata;
      bus.mem_be    = head.be;
    end
  end

  assign bus.st_ready     = !full;
  assign bus.mem_valid    = !empty;
  assign bus.misalign_err = err_q;
  assign bus.count        = count_q;
endmodule

// File: doc/store_narrow_buffer.md
Name: store_narrow_buffer

Overview:
Store-side counterpart of the sign-extension path. ExtensionSigno widens narrow values to 32 bits; this block narrows 32-bit register values for SB/SH/SW. It sits between the MEM stage and data memory. It takes a store request, produces a word-aligned address, a lane-replicated data word and byte enables, and queues the result in a small FIFO. The FIFO drains to data memory over a valid/ready handshake, so memory stalls do not immediately stall the pipeline.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, minimum 2.
CNT_W, 3, width of the occupancy count; must satisfy 2^CNT_W > DEPTH.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
st_valid  in  1  a store request is presented.
st_ready  out  1  block can accept a request; equals !full.
st_size  in  2  store size: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
st_addr  in  32  byte address.
st_data  in  32  register value; only the low byte or low halfword is used for SB/SH.
misalign_err  out  1  one-cycle pulse when an accepted request is illegal.
mem_valid  out  1  head entry is presented to memory; equals !empty.
mem_ready  in  1  memory accepts the head entry.
mem_addr  out  32  word-aligned address: {st_addr[31:2], 2'b00}.
mem_wdata  out  32  lane-replicated write data.
mem_be  out  4  byte enables; bit k enables byte lane k (little-endian).
count  out  CNT_W  number of occupied entries.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - read pointer, write pointer and count cleared to 0.
  - misalign_err = 0; mem_valid = 0; st_ready = 1.
  - mem_addr, mem_wdata and mem_be read as 0 while the FIFO is empty.
  - If reset is asserted mid-operation, all queued entries are discarded and no memory write occurs after it.
- Request handshake:
  - A request is accepted on an edge where st_valid && st_ready.
  - Requesters hold st_* stable until accepted.
- Narrowing, computed combinationally from the request and stored per entry:
  - Byte: be = 4'b0001 << st_addr[1:0]; wdata = {4{st_data[7:0]}}.
  - Halfword: be = st_addr[1] ? 4'b1100 : 4'b0011; wdata = {2{st_data[15:0]}}.
  - Word: be = 4'b1111; wdata = st_data.
- Illegal requests:
  - Halfword with st_addr[0] = 1, word with st_addr[1:0] != 0, and st_size = 11 are illegal.
  - An illegal request is still handshaken (consumed) but is NOT enqueued.
  - misalign_err is registered and goes high for exactly the cycle after acceptance.
  - count is unchanged.
- Drain side:
  - mem_* outputs come directly from the head entry (no combinational path from st_* to mem_*).
  - Minimum latency is 1 cycle: a request accepted at edge N appears on mem_* after edge N.
  - mem_addr, mem_wdata and mem_be stay stable while mem_valid && !mem_ready.
  - The head entry is popped on an edge where mem_valid && mem_ready.
- Simultaneous push and pop:
  - Legal push plus pop: count unchanged; both pointers advance.
  - Full plus pop: the push is refused because st_ready = 0 that cycle. There is no same-cycle bypass; st_ready rises the next cycle.
  - Empty: no pop is possible since mem_valid = 0. A push into an empty FIFO is not visible to memory until the next cycle.
- Pointers wrap modulo DEPTH. Ordering is strictly FIFO: memory sees legal stores in acceptance order.
- mem_ready asserted while mem_valid = 0 is ignored.

Test Plan:
1. Byte store: SB, addr 0x1003, data 0xAABBCC7E, mem_ready = 1 → one cycle later mem_addr = 0x1000, mem_be = 1000, mem_wdata = 0x7E7E7E7E, popped; count returns to 0.
2. Halfword and word stores: SH, addr 0x2002, data 0x1234BEEF → be = 1100, wdata = 0xBEEFBEEF. Then SW, addr 0x2004, data 0xCAFEF00D → be = 1111, wdata = 0xCAFEF00D, delivered in that order.
3. Misaligned requests: SH addr 0x3001, SW addr 0x3002 and st_size = 11, each with st_valid = 1 → each is accepted, misalign_err pulses for 1 cycle each time, count stays 0, mem_valid stays 0.
4. Fill and backpressure: mem_ready = 0, push 5 legal SWs (addr 0x0, 0x4, 0x8, 0xC, 0x10) → count = 4 and st_ready = 0 after the 4th; the 5th is held. Raise mem_ready → data drains as 0x0, 0x4, 0x8, 0xC, then 0x10, with mem_* stable during the stall.
5. Simultaneous push/pop while full: count = 4, mem_ready = 1, st_valid = 1 → that cycle only the pop occurs (count = 3). The next cycle the push and pop both occur and count stays 3.
6. Reset mid-operation: 3 entries queued, pull rst_n low asynchronously between edges → mem_valid = 0, count = 0 and st_ready = 1 immediately. After release, a new SB to 0x40 with data 0x11 gives be = 0001, wdata = 0x11111111.
